// File: rtl/mpi_noc_out_arbiter.sv
// mpi_noc_out_arbiter
// Merges N per-endpoint NoC output channels onto one registered output link.
// Arbitration is round-robin. A multi-flit packet locks its channel until
// the last flit is accepted, so packets never interleave.
//
// Handshake: a flit moves on any channel (input or output) only in a cycle
// where valid and ready are both high at the rising edge of clk. in_ready is
// derived from the arbiter state and the output stage, never from the same
// channel's in_valid, except in IDLE where in_valid picks the candidate.
// in_last is meaningful only while in_valid is high.
module mpi_noc_out_arbiter #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int N              = 1,
    localparam int PTR_W         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N*NOC_FLIT_WIDTH-1:0] in_flit,
    input  logic [N-1:0]                in_last,
    input  logic [N-1:0]                in_valid,
    output logic [N-1:0]                in_ready,
    input  logic [N-1:0]                chan_en,
    output logic [NOC_FLIT_WIDTH-1:0]   out_flit,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                grant,
    output logic                        busy,
    output logic [0:0]                  dbg_state,
    output logic [PTR_W-1:0]            dbg_rr_ptr
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]                state;
    logic [PTR_W-1:0]          rr_ptr;
    logic [PTR_W-1:0]          owner;
    logic [N-1:0]              cand;
    logic [PTR_W-1:0]          sel;
    logic                      found;
    int                        scan_idx;
    logic [N-1:0]              one_hot_sel;
    logic                      stage_free;
    logic                      xfer;
    logic [PTR_W-1:0]          mux_idx;
    logic [NOC_FLIT_WIDTH-1:0] mux_flit;
    logic                      mux_last;

    // Next round-robin position after channel p, wrapping N-1 -> 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == N - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign cand       = in_valid & chan_en;
    assign stage_free = !out_valid || out_ready;

    // Cyclic search for the first enabled, valid channel at or after rr_ptr.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < N; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!found && cand[scan_idx]) begin
                sel   = PTR_W'(scan_idx);
                found = 1'b1;
            end
        end
    end

    // One-hot form of the selected channel.
    always_comb begin
        one_hot_sel      = '0;
        one_hot_sel[sel] = 1'b1;
    end

    // Ready goes only to the lock owner, or to the selected candidate in IDLE.
    always_comb begin
        in_ready = '0;
        if (!rst) begin
            if (state == ST_LOCKED) begin
                in_ready = grant & {N{stage_free}};
            end else if (found) begin
                in_ready = one_hot_sel & {N{stage_free}};
            end
        end
    end

    assign xfer    = |(in_valid & in_ready);
    assign mux_idx = (state == ST_LOCKED) ? owner : sel;

    // Route the accepted channel's flit and last marker to the output stage.
    always_comb begin
        mux_flit = '0;
        mux_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(mux_idx) == i) begin
                mux_flit = in_flit[i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
                mux_last = in_last[i];
            end
        end
    end

    // Registered output stage: load on transfer, clear when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_flit  <= mux_flit;
            out_last  <= mux_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Arbiter FSM: single-flit packets stay IDLE, longer ones lock the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            owner  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        if (mux_last) begin
                            rr_ptr <= ptr_inc(sel);
                        end else begin
                            state <= ST_LOCKED;
                            grant <= one_hot_sel;
                            owner <= sel;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (xfer && mux_last) begin
                        state  <= ST_IDLE;
                        grant  <= '0;
                        rr_ptr <= ptr_inc(owner);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign busy       = (state == ST_LOCKED) || out_valid;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_mpi_noc_out_arbiter.sv
// Directed bench for mpi_noc_out_arbiter with N=4, 32-bit flits.
module tb_mpi_noc_out_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_flit;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   chan_en;
  logic [W-1:0]   out_flit;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic [0:0]     dbg_state;
  logic [1:0]     dbg_rr_ptr;

  mpi_noc_out_arbiter #(.NOC_FLIT_WIDTH(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .chan_en    (chan_en),
    .out_flit   (out_flit),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant      (grant),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];   // {last, flit} in expected output order
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int ch, input logic [W-1:0] f, input logic l, input logic v);
    in_flit[ch*W +: W] = f;
    in_last[ch]        = l;
    in_valid[ch]       = v;
  endtask

  // Advance one cycle; any output flit handed downstream at this edge is
  // checked against the head of the expected queue.
  task automatic step();
    if (out_valid && out_ready) begin
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        check("sb_flit", 64'({out_last, out_flit}), 64'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    in_flit   = '0;
    in_last   = '0;
    in_valid  = '0;
    chan_en   = 4'hF;
    out_ready = 1'b1;
    rst       = 1'b1;

    // Reset: in_ready held low even with all channels valid.
    in_valid = 4'hF;
    settle();
    check("rst_in_ready", 64'(in_ready), 64'h0);
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_flit", 64'(out_flit), 64'h0);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);
    check("rst_rr_ptr", 64'(dbg_rr_ptr), 64'h0);

    // Test 1: continuous single-flit packets rotate C0..C3.
    for (int c = 0; c < N; c++) set_ch(c, 32'hC0 + 32'(c), 1'b1, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle();
      check("t1_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
      exp_q.push_back({1'b1, 32'hC0 + 32'(k % 4)});
      step();
      check("t1_out_valid", 64'(out_valid), 64'h1);
      check("t1_out_flit", 64'(out_flit), 64'h0C0 + 64'(k % 4));
    end
    in_valid = '0;
    step();
    check("t1_drained", 64'(out_valid), 64'h0);
    check("t1_rr_ptr", 64'(dbg_rr_ptr), 64'h0);

    // Test 2: ch1 3-flit packet while ch2 waits.
    set_ch(1, 32'h10, 1'b0, 1'b1);
    set_ch(2, 32'h20, 1'b1, 1'b1);
    settle();
    check("t2_ready_f0", 64'(in_ready), 64'b0010);
    exp_q.push_back({1'b0, 32'h10});
    step();
    check("t2_grant_f0", 64'(grant), 64'b0010);
    set_ch(1, 32'h11, 1'b0, 1'b1);
    settle();
    check("t2_ready_f1", 64'(in_ready), 64'b0010);
    exp_q.push_back({1'b0, 32'h11});
    step();
    check("t2_grant_f1", 64'(grant), 64'b0010);
    check("t2_out_f1", 64'(out_flit), 64'h11);
    set_ch(1, 32'h12, 1'b1, 1'b1);
    settle();
    check("t2_ready_f2", 64'(in_ready), 64'b0010);
    exp_q.push_back({1'b1, 32'h12});
    step();
    check("t2_grant_end", 64'(grant), 64'b0000);
    check("t2_rr_ptr", 64'(dbg_rr_ptr), 64'h2);
    set_ch(1, 32'h0, 1'b0, 1'b0);
    settle();
    check("t2_ready_ch2", 64'(in_ready), 64'b0100);
    exp_q.push_back({1'b1, 32'h20});
    step();
    check("t2_out_ch2", 64'(out_flit), 64'h20);
    set_ch(2, 32'h0, 1'b0, 1'b0);
    step();
    check("t2_idle", 64'(out_valid), 64'h0);
    check("t2_rr_ptr_end", 64'(dbg_rr_ptr), 64'h3);

    // Test 3: 4-flit packet on ch3 stalled 5 cycles after flit 2.
    set_ch(3, 32'h30, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 32'h30});
    step();
    set_ch(3, 32'h31, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 32'h31});
    step();
    set_ch(3, 32'h32, 1'b0, 1'b1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("t3_stall_ready", 64'(in_ready), 64'h0);
      step();
      check("t3_stall_flit", 64'({out_valid, out_last, out_flit}), 64'h2_0000_0031);
      check("t3_stall_grant", 64'(grant), 64'b1000);
    end
    out_ready = 1'b1;
    settle();
    check("t3_resume_ready", 64'(in_ready), 64'b1000);
    exp_q.push_back({1'b0, 32'h32});
    step();
    set_ch(3, 32'h33, 1'b1, 1'b1);
    exp_q.push_back({1'b1, 32'h33});
    step();
    check("t3_last_out", 64'({out_last, out_flit}), 64'h1_0000_0033);
    set_ch(3, 32'h0, 1'b0, 1'b0);
    step();
    check("t3_drained", 64'(exp_q.size()), 64'h0);
    check("t3_rr_ptr", 64'(dbg_rr_ptr), 64'h0);

    // Test 4: ch0 masked by chan_en while ch0 and ch3 are valid.
    chan_en = 4'b1110;
    set_ch(0, 32'h40, 1'b1, 1'b1);
    set_ch(3, 32'h43, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t4_masked_ready", 64'(in_ready), 64'b1000);
      exp_q.push_back({1'b1, 32'h43});
      step();
      check("t4_out_ch3", 64'(out_flit), 64'h43);
    end
    chan_en = 4'hF;
    settle();
    check("t4_unmask_ready", 64'(in_ready), 64'b0001);
    exp_q.push_back({1'b1, 32'h40});
    step();
    check("t4_out_ch0", 64'(out_flit), 64'h40);
    in_valid = '0;
    step();
    check("t4_rr_ptr", 64'(dbg_rr_ptr), 64'h1);

    // Test 5: reset while ch2 holds the lock.
    set_ch(2, 32'h50, 1'b0, 1'b1);
    settle();
    check("t5_ready_ch2", 64'(in_ready), 64'b0100);
    exp_q.push_back({1'b0, 32'h50});
    step();
    check("t5_locked_grant", 64'(grant), 64'b0100);
    check("t5_locked_state", 64'(dbg_state), 64'h1);
    check("t5_locked_busy", 64'(busy), 64'h1);
    for (int c = 0; c < N; c++) set_ch(c, 32'hC0 + 32'(c), 1'b1, 1'b1);
    rst = 1'b1;
    settle();
    check("t5_rst_ready", 64'(in_ready), 64'h0);
    step();
    check("t5_out_valid", 64'(out_valid), 64'h0);
    check("t5_grant", 64'(grant), 64'h0);
    check("t5_busy", 64'(busy), 64'h0);
    check("t5_rr_ptr", 64'(dbg_rr_ptr), 64'h0);
    check("t5_state", 64'(dbg_state), 64'h0);
    rst = 1'b0;
    settle();
    check("t5_ch0_wins", 64'(in_ready), 64'b0001);
    exp_q.push_back({1'b1, 32'hC0});
    step();
    check("t5_out_ch0", 64'(out_flit), 64'hC0);
    in_valid = '0;
    step();

    // Test 6: in_last without in_valid does nothing.
    in_last = 4'hF;
    settle();
    check("t6_ready", 64'(in_ready), 64'h0);
    step();
    step();
    check("t6_out_valid", 64'(out_valid), 64'h0);
    check("t6_state", 64'(dbg_state), 64'h0);
    check("t6_grant", 64'(grant), 64'h0);
    check("t6_rr_ptr", 64'(dbg_rr_ptr), 64'h1);
    check("t6_queue_empty", 64'(exp_q.size()), 64'h0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
